// File: rtl/cmd_pkg.sv
// Shared command-link definitions: opcodes, transmitter states and default baud divisor.
package cmd_pkg;

  localparam logic [1:0] CMD_GO   = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b00;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  function automatic logic [7:0] encode_cmd(input logic [1:0] op, input logic [5:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: shifter, baud counter, bit counter and frame FSM.
module uart_tx_core
  import cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       idle,
  output logic       ready
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  tx_state_e   state;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign idle     = (state == IDLE);
  // ready marks the cycles where trmt is sampled: idle, or the last clock of the stop bit
  assign ready    = idle | ((state == STOP) & baud_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      baud_cnt <= (idle || baud_end) ? '0 : baud_cnt + 12'd1;
      case (state)
        IDLE: if (trmt) begin
          shift <= tx_data;
          TX    <= 1'b0;
          state <= START;
        end
        START: if (baud_end) begin
          TX      <= shift[0];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            TX    <= 1'b1;
            state <= STOP;
          end else begin
            shift   <= {1'b0, shift[7:1]};
            TX      <= shift[1];
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: if (baud_end) begin
          tx_done <= 1'b1;
          if (trmt) begin
            shift <= tx_data;
            TX    <= 1'b0;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_tx.sv
// Command transmitter: encodes GO/STOP requests, buffers one request and feeds the UART core.
module cmd_tx
  import cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter bit          HOLD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_go,
  input  logic       send_stop,
  input  logic [5:0] dest_ID,
  output logic       TX,
  output logic       busy,
  output logic       tx_done,
  output logic       ovrflw,
  output logic [7:0] last_cmd
);

  logic [7:0] req_byte, hold_byte, core_data;
  logic       req_valid, hold_valid, hold_next;
  logic       direct, capture, core_trmt, core_idle, core_ready;

  always_comb begin
    req_valid = send_go | send_stop;
    req_byte  = send_stop ? encode_cmd(CMD_STOP, 6'h00) : encode_cmd(CMD_GO, dest_ID);
    direct    = core_idle & ~hold_valid & req_valid;
    // hold state is judged before this cycle's hand-off, so a full hold drops the request
    capture   = HOLD_EN & req_valid & ~direct & ~hold_valid;
    core_trmt = hold_valid | direct;
    core_data = hold_valid ? hold_byte : req_byte;
    hold_next = capture | (hold_valid & ~core_ready);
  end

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (core_trmt),
    .tx_data (core_data),
    .TX      (TX),
    .tx_done (tx_done),
    .idle    (core_idle),
    .ready   (core_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      ovrflw     <= 1'b0;
      last_cmd   <= '0;
      busy       <= 1'b0;
    end else begin
      if (capture) hold_byte <= req_byte;
      hold_valid <= hold_next;
      ovrflw     <= req_valid & ~direct & ~capture;
      if (core_ready & core_trmt) last_cmd <= core_data;
      busy       <= ~(core_ready & ~core_trmt) | hold_next;
    end
  end

endmodule

// File: tb/tb_cmd_tx.sv
// Directed self-checking bench for cmd_tx at BAUD_DIV=8.
module tb_cmd_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_go = 1'b0;
  logic       send_stop = 1'b0;
  logic [5:0] dest_ID = '0;
  logic       TX, busy, tx_done, ovrflw;
  logic [7:0] last_cmd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cmd_tx #(.BAUD_DIV(8), .HOLD_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_go   (send_go),
    .send_stop (send_stop),
    .dest_ID   (dest_ID),
    .TX        (TX),
    .busy      (busy),
    .tx_done   (tx_done),
    .ovrflw    (ovrflw),
    .last_cmd  (last_cmd)
  );

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Called on a falling edge; holds the request for one clock.
  task automatic req(input logic go, input logic stop, input logic [5:0] id);
    send_go   = go;
    send_stop = stop;
    dest_ID   = id;
    @(negedge clk);
    send_go   = 1'b0;
    send_stop = 1'b0;
  endtask

  // Starts on the falling edge where TX first reads 0; ends 80 clocks later.
  task automatic capture_frame(output logic [9:0] bits, output int done_at, output int done_cnt,
                               output int ovf_cnt, output logic busy_dropped);
    bits = '1; done_at = -1; done_cnt = 0; ovf_cnt = 0; busy_dropped = 1'b0;
    for (int k = 0; k <= 80; k++) begin
      if (k % 8 == 3) bits[k/8] = TX;
      if (k > 0 && tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (ovrflw) ovf_cnt++;
      if (k < 80 && !busy) busy_dropped = 1'b1;
      if (k < 80) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int dones = 0, lows = 0, busys = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (TX !== 1'b1) $display("FAIL reset_tx: got %b exp 1", TX); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
    total++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", tx_done); else passed++;
    total++; if (ovrflw !== 1'b0) $display("FAIL reset_ovrflw: got %b exp 0", ovrflw); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL reset_last_cmd: got %h exp 00", last_cmd); else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (TX !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    total++; if (dones != 0) $display("FAIL idle_done: got %0d exp 0", dones); else passed++;
    total++; if (lows != 0) $display("FAIL idle_tx: got %0d low cycles exp 0", lows); else passed++;
    total++; if (busys != 0) $display("FAIL idle_busy: got %0d busy cycles exp 0", busys); else passed++;
  endtask

  task automatic test_single_go();
    logic [9:0] bits; int d_at, d_cnt, ovf; logic bd;
    req(1'b1, 1'b0, 6'h35);
    total++; if (TX !== 1'b0) $display("FAIL go_latency: got %b exp 0", TX); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL go_busy: got %b exp 1", busy); else passed++;
    total++; if (last_cmd !== 8'h75) $display("FAIL go_last_cmd: got %h exp 75", last_cmd); else passed++;
    capture_frame(bits, d_at, d_cnt, ovf, bd);
    total++; if (bits !== frame_of(8'h75)) $display("FAIL go_frame: got %b exp %b", bits, frame_of(8'h75)); else passed++;
    total++; if (d_at != 80) $display("FAIL go_done_time: got %0d exp 80", d_at); else passed++;
    total++; if (d_cnt != 1) $display("FAIL go_done_count: got %0d exp 1", d_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL go_busy_end: got %b exp 0", busy); else passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] b1, b2; int a1, a2, c1, c2, o1, o2; logic bd1, bd2;
    req(1'b1, 1'b0, 6'h03);
    fork
      capture_frame(b1, a1, c1, o1, bd1);
      begin
        repeat (19) @(negedge clk);
        req(1'b0, 1'b1, 6'h00);
      end
    join
    capture_frame(b2, a2, c2, o2, bd2);
    total++; if (b1 !== frame_of(8'h43)) $display("FAIL b2b_frame1: got %b exp %b", b1, frame_of(8'h43)); else passed++;
    total++; if (b2 !== frame_of(8'h00)) $display("FAIL b2b_frame2: got %b exp %b", b2, frame_of(8'h00)); else passed++;
    total++; if ({bd1, bd2} !== 2'b00) $display("FAIL b2b_busy_gap: got %b exp 00", {bd1, bd2}); else passed++;
    total++; if (c1 + c2 != 2 || a1 != 80 || a2 != 80) $display("FAIL b2b_done: got %0d pulses at %0d/%0d exp 2 at 80/80", c1 + c2, a1, a2); else passed++;
    total++; if (o1 + o2 != 0) $display("FAIL b2b_ovrflw: got %0d exp 0", o1 + o2); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b exp 0", busy); else passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [9:0] b1, b2; int a1, a2, c1, c2, o1, o2; logic bd1, bd2;
    int lows = 0;
    req(1'b1, 1'b0, 6'h11);
    fork
      capture_frame(b1, a1, c1, o1, bd1);
      begin
        repeat (4) @(negedge clk);
        req(1'b1, 1'b0, 6'h22);
        repeat (4) @(negedge clk);
        req(1'b0, 1'b1, 6'h00);
      end
    join
    capture_frame(b2, a2, c2, o2, bd2);
    total++; if (o1 != 1) $display("FAIL ovf_pulse: got %0d exp 1", o1); else passed++;
    total++; if (b1 !== frame_of(8'h51)) $display("FAIL ovf_frame1: got %b exp %b", b1, frame_of(8'h51)); else passed++;
    total++; if (b2 !== frame_of(8'h62)) $display("FAIL ovf_frame2: got %b exp %b", b2, frame_of(8'h62)); else passed++;
    total++; if (busy !== 1'b0 || bd1 !== 1'b0) $display("FAIL ovf_busy: got end %b gap %b exp 0 0", busy, bd1); else passed++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    total++; if (lows != 0) $display("FAIL ovf_third_frame: got %0d low cycles exp 0", lows); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [9:0] bits; int d_at, d_cnt, ovf; logic bd;
    req(1'b1, 1'b1, 6'h3F);
    capture_frame(bits, d_at, d_cnt, ovf, bd);
    total++; if (bits !== frame_of(8'h00)) $display("FAIL sim_frame: got %b exp %b", bits, frame_of(8'h00)); else passed++;
    total++; if (ovf != 0) $display("FAIL sim_ovrflw: got %0d exp 0", ovf); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL sim_last_cmd: got %h exp 00", last_cmd); else passed++;
    total++; if (d_cnt != 1) $display("FAIL sim_done_count: got %0d exp 1", d_cnt); else passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int lows = 0, dones = 0, busys = 0;
    req(1'b1, 1'b0, 6'h2A);
    repeat (2) @(negedge clk);
    req(1'b1, 1'b0, 6'h15);
    repeat (40) @(negedge clk);
    total++; if (TX !== 1'b0 || busy !== 1'b1) $display("FAIL rst_pre: got tx %b busy %b exp 0 1", TX, busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (TX !== 1'b1) $display("FAIL rst_async_tx: got %b exp 1", TX); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL rst_last_cmd: got %h exp 00", last_cmd); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
      if (tx_done) dones++;
      if (busy) busys++;
    end
    total++; if (lows + dones + busys != 0) $display("FAIL rst_no_frames: got low %0d done %0d busy %0d exp 0", lows, dones, busys); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_go();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
